vga_frame_reader: RTL and testbench

// - VGA-side reader of the Memory stage's video port. Generates 640x480@60 timing and drives DataAdr_VGA.
// - Takes the returned 8-bit grayscale pixel and drives the DAC.
// - Image is W x H at address 0, row-major, shown at screen top-left. Everything outside it is black.
// - CPU writes use the Memory stage's other port. This block only reads.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_frame_reader_if.sv | 23 ++
 rtl/vga_timing_gen.sv | 73 +++++++
 rtl/vga_frame_reader.sv | 124 ++++++++++++
 tb/tb_vga_frame_reader.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), sync bundle type and memory address width
// for the frame reader and its timing generator.
package vga_pkg;

    localparam int unsigned VGA_H_ACT    = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SW     = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACT    = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SW     = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACT + VGA_H_FP + VGA_H_SW + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACT + VGA_V_FP + VGA_V_SW + VGA_V_BP;
    localparam int unsigned VGA_HS_START = VGA_H_ACT + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SW - 1;
    localparam int unsigned VGA_VS_START = VGA_V_ACT + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SW - 1;

    localparam int unsigned VGA_ADDR_W   = 19;
    localparam int unsigned CNT_W        = 10;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } vga_sync_t;

    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_frame_reader_if.sv
// Video read port between the frame reader (master) and the memory stage (slave),
// plus the image size supplied alongside it.
interface vga_frame_reader_if
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W = VGA_ADDR_W
);
    logic [15:0]       dimensiones;
    logic [7:0]        pixel;
    logic [ADDR_W-1:0] DataAdr_VGA;

    modport master (
        output DataAdr_VGA,
        input  pixel,
        input  dimensiones
    );

    modport slave (
        input  DataAdr_VGA,
        output pixel,
        output dimensiones
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider and horizontal/vertical counters; produces raw (undelayed)
// sync/active flags and a registered one-clk frame_start pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT = VGA_H_ACT,
    parameter int unsigned H_FP  = VGA_H_FP,
    parameter int unsigned H_SW  = VGA_H_SW,
    parameter int unsigned H_BP  = VGA_H_BP,
    parameter int unsigned V_ACT = VGA_V_ACT,
    parameter int unsigned V_FP  = VGA_V_FP,
    parameter int unsigned V_SW  = VGA_V_SW,
    parameter int unsigned V_BP  = VGA_V_BP
)(
    input  logic             clk,
    input  logic             reset,
    output logic             pe_o,
    output logic [CNT_W-1:0] hc_o,
    output logic [CNT_W-1:0] vc_o,
    output vga_sync_t        sync_o,
    output logic             frame_start_o
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACT + H_FP + H_SW + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACT + V_FP + V_SW + V_BP - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FP + H_SW - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FP + V_SW - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);

    logic             pe_q;
    logic             fs_q;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_q <= 1'b0;
            fs_q <= 1'b0;
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            pe_q <= ~pe_q;
            fs_q <= pe_q && (hc_q == '0) && (vc_q == '0);
            if (pe_q) begin
                hc_q <= hc_d;
                vc_q <= vc_d;
            end
        end
    end

    always_comb begin
        sync_o.hs  = !((hc_q >= HS_START) && (hc_q <= HS_END));
        sync_o.vs  = !((vc_q >= VS_START) && (vc_q <= VS_END));
        sync_o.act = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    end

    assign pe_o          = pe_q;
    assign hc_o          = hc_q;
    assign vc_o          = vc_q;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_frame_reader.sv
// VGA-side reader of the video memory port: issues row-major pixel addresses for a
// W x H grayscale image at the screen's top-left and drives the DAC.
// Define ZOOM2X_EN to show the image at 2x (each source pixel repeated 2x2).
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT  = VGA_H_ACT,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SW   = VGA_H_SW,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_ACT  = VGA_V_ACT,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SW   = VGA_V_SW,
    parameter int unsigned V_BP   = VGA_V_BP,
    parameter int unsigned ADDR_W = VGA_ADDR_W
)(
    input  logic               clk,
    input  logic               reset,
    vga_frame_reader_if.master mem,
    output logic               vga_clk,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               frame_start
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACT + H_FP + H_SW + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACT + V_FP + V_SW + V_BP - 1);

    logic              pe;
    logic [CNT_W-1:0]  hc, vc;
    vga_sync_t         sync_raw;

    logic [7:0]        w_q, h_q, w_eff, h_eff;
    logic [CNT_W-1:0]  x, y;
    logic              frame_first, row_step, in_img;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_img_q;
    vga_sync_t         sync_q, out_q;
    logic [7:0]        rgb_q;

    vga_timing_gen #(
        .H_ACT (H_ACT), .H_FP (H_FP), .H_SW (H_SW), .H_BP (H_BP),
        .V_ACT (V_ACT), .V_FP (V_FP), .V_SW (V_SW), .V_BP (V_BP)
    ) u_timing (
        .clk           (clk),
        .reset         (reset),
        .pe_o          (pe),
        .hc_o          (hc),
        .vc_o          (vc),
        .sync_o        (sync_raw),
        .frame_start_o (frame_start)
    );

    always_comb begin
        frame_first = (hc == '0) && (vc == '0);
        // The size is sampled on the frame's first tick so pixel (0,0) already uses it.
        w_eff = frame_first ? mem.dimensiones[15:8] : w_q;
        h_eff = frame_first ? mem.dimensiones[7:0]  : h_q;
`ifdef ZOOM2X_EN
        x        = {1'b0, hc[CNT_W-1:1]};
        y        = {1'b0, vc[CNT_W-1:1]};
        row_step = vc[0];
`else
        x        = hc;
        y        = vc;
        row_step = 1'b1;
`endif
        in_img = (x < {2'b00, w_eff}) && (y < {2'b00, h_eff});

        addr_d = addr_q;
        if (in_img)
            addr_d = row_base_q + ADDR_W'(x);
        else if (frame_first)
            addr_d = '0;

        // Row base is cleared on the frame's last tick so it is already 0 at frame start.
        row_base_d = row_base_q;
        if (hc == H_LAST) begin
            if (vc == V_LAST)
                row_base_d = '0;
            else if (row_step && (y < {2'b00, h_q}))
                row_base_d = row_base_q + ADDR_W'(w_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q        <= '0;
            h_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            in_img_q   <= 1'b0;
            sync_q     <= SYNC_IDLE;
            out_q      <= SYNC_IDLE;
            rgb_q      <= '0;
        end else if (pe) begin
            w_q        <= w_eff;
            h_q        <= h_eff;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            in_img_q   <= in_img;
            sync_q     <= sync_raw;
            // Syncs take the extra stage too, so they stay aligned with the returned pixel.
            out_q      <= sync_q;
            rgb_q      <= (in_img_q && sync_q.act) ? mem.pixel : '0;
        end
    end

    assign mem.DataAdr_VGA = addr_q;
    assign vga_clk         = pe;
    assign vga_hsync       = out_q.hs;
    assign vga_vsync       = out_q.vs;
    assign vga_blank_n     = out_q.act;
    assign vga_sync_n      = 1'b0;
    assign vga_r           = rgb_q;
    assign vga_g           = rgb_q;
    assign vga_b           = rgb_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader on a reduced screen geometry, with a
// memory model returning pixel = address[7:0] one clk after the address.
module tb_vga_frame_reader;
    import vga_pkg::*;

    localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
    localparam int VA = 12, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam int AW = VGA_ADDR_W;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_clk, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] cur_dim;
    logic [AW-1:0] obs_addr [FT];
    logic [7:0]    obs_rgb  [FT];

    vga_frame_reader_if #(.ADDR_W(AW)) mem ();

    vga_frame_reader #(
        .H_ACT (HA), .H_FP (HF), .H_SW (HSW), .H_BP (HB),
        .V_ACT (VA), .V_FP (VF), .V_SW (VSW), .V_BP (VB),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (mem),
        .vga_clk     (vga_clk),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    always @(posedge clk) mem.pixel <= mem.DataAdr_VGA[7:0];

    function automatic int px_x(input int h);
`ifdef ZOOM2X_EN
        return h / 2;
`else
        return h;
`endif
    endfunction

    function automatic int px_y(input int v);
`ifdef ZOOM2X_EN
        return v / 2;
`else
        return v;
`endif
    endfunction

    task automatic next_tick();
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (vga_clk !== 1'b0 && k < 4);
        if (k >= 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_wait: vga_clk stuck at %b, expected toggling", vga_clk);
        end
    endtask

    // Starts at the sample point right after a frame's first tick; ends at the next one.
    task automatic run_frame(input string tag, input int change_tick, input logic [15:0] next_dim);
        int w, hh, h, v, ph, pv, ea, prev_ea;
        bit pin, pbl;
        logic [3:0] esync;
        logic [7:0] er;
        w  = int'(cur_dim[15:8]);
        hh = int'(cur_dim[7:0]);
        ea = 0;
        for (int n = 0; n < FT; n++) begin
            if (n > 0) next_tick();
            h = n % HT;
            v = n / HT;
            prev_ea = ea;
            if (px_x(h) < w && px_y(v) < hh) ea = px_y(v) * w + px_x(h);
            else if (n == 0) ea = 0;
            obs_addr[n] = mem.DataAdr_VGA;
            obs_rgb[n]  = vga_r;
            n_cmp++;
            if (mem.DataAdr_VGA !== AW'(ea)) begin
                n_bad++;
                $display("FAIL %s addr n=%0d: got %0d expected %0d", tag, n, mem.DataAdr_VGA, ea);
            end
            n_cmp++;
            if (frame_start !== (n == 0)) begin
                n_bad++;
                $display("FAIL %s frame_start n=%0d: got %b expected %b", tag, n, frame_start, n == 0);
            end
            if (n > 0) begin
                ph  = (n - 1) % HT;
                pv  = (n - 1) / HT;
                pin = px_x(ph) < w && px_y(pv) < hh;
                pbl = ph < HA && pv < VA;
                esync = {!(ph >= HA + HF && ph < HA + HF + HSW),
                         !(pv >= VA + VF && pv < VA + VF + VSW), pbl, 1'b0};
                er = (pin && pbl) ? 8'(prev_ea) : 8'h00;
                n_cmp++;
                if ({vga_hsync, vga_vsync, vga_blank_n, vga_sync_n} !== esync) begin
                    n_bad++;
                    $display("FAIL %s sync n=%0d: got hs/vs/blank/sync_n %b%b%b%b expected %b",
                             tag, n, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, esync);
                end
                n_cmp++;
                if ({vga_r, vga_g, vga_b} !== {er, er, er}) begin
                    n_bad++;
                    $display("FAIL %s rgb n=%0d: got %h/%h/%h expected %h", tag, n, vga_r, vga_g, vga_b, er);
                end
            end
            if (n == change_tick) mem.dimensiones = next_dim;
        end
        next_tick();
        cur_dim = mem.dimensiones;
    endtask

    task automatic test_reset();
        int n;
        repeat (301) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) #1;
            else @(negedge clk);
            n_cmp++;
            if ({vga_clk, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start} !== 6'b011000) begin
                n_bad++;
                $display("FAIL reset_ctrl s=%0d: got %b expected 011000", i,
                         {vga_clk, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start});
            end
            n_cmp++;
            if ({vga_r, vga_g, vga_b, mem.DataAdr_VGA} !== '0) begin
                n_bad++;
                $display("FAIL reset_data s=%0d: got rgb %h addr %0d expected 0", i, vga_r, mem.DataAdr_VGA);
            end
        end
        reset = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_start !== 1'b1 && n < 10);
        n_cmp++;
        if (n != 2) begin
            n_bad++;
            $display("FAIL reset_release: frame_start after %0d clk, expected 2", n);
        end
        cur_dim = mem.dimensiones;
    endtask

    task automatic test_timing();
        int clk_n = 0, falls = 0, f1 = -1, f2 = -1, hs_low1 = 0, vs_low = 0, fs_hi = 0;
        logic prev_hs = vga_hsync;
        do begin
            @(posedge clk);
            #1;
            clk_n++;
            if (prev_hs === 1'b1 && vga_hsync === 1'b0) begin
                falls++;
                if (falls == 1) f1 = clk_n;
                if (falls == 2) f2 = clk_n;
            end
            if (falls == 1 && vga_hsync === 1'b0) hs_low1++;
            if (vga_vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) fs_hi++;
            prev_hs = vga_hsync;
        end while (frame_start !== 1'b1 && clk_n < 2 * FT + 10);
        n_cmp++;
        if (clk_n != 2 * FT) begin
            n_bad++; $display("FAIL frame_len: got %0d clk expected %0d", clk_n, 2 * FT);
        end
        n_cmp++;
        if (falls != VT) begin
            n_bad++; $display("FAIL lines_per_frame: got %0d expected %0d", falls, VT);
        end
        n_cmp++;
        if (f2 - f1 != 2 * HT) begin
            n_bad++; $display("FAIL hsync_period: got %0d clk expected %0d", f2 - f1, 2 * HT);
        end
        n_cmp++;
        if (hs_low1 != 2 * HSW) begin
            n_bad++; $display("FAIL hsync_width: got %0d clk expected %0d", hs_low1, 2 * HSW);
        end
        n_cmp++;
        if (vs_low != 2 * VSW * HT) begin
            n_bad++; $display("FAIL vsync_width: got %0d clk expected %0d", vs_low, 2 * VSW * HT);
        end
        n_cmp++;
        if (fs_hi != 1) begin
            n_bad++; $display("FAIL frame_start_pulses: got %0d expected 1", fs_hi);
        end
        cur_dim = mem.dimensiones;
    endtask

    task automatic test_image_4x3();
        logic [AW-1:0] e0, e2;
        logic [7:0]    e11;
        run_frame("img4x3", -1, 16'h0403);
        for (int i = 0; i < 4; i++) begin
`ifdef ZOOM2X_EN
            e0 = AW'(i / 2);
            e2 = AW'(4 + i / 2);
`else
            e0 = AW'(i);
            e2 = AW'(8 + i);
`endif
            n_cmp++;
            if (obs_addr[i] !== e0) begin
                n_bad++; $display("FAIL img4x3_line0 x=%0d: got %0d expected %0d", i, obs_addr[i], e0);
            end
            n_cmp++;
            if (obs_addr[2 * HT + i] !== e2) begin
                n_bad++; $display("FAIL img4x3_line2 x=%0d: got %0d expected %0d", i, obs_addr[2 * HT + i], e2);
            end
        end
`ifdef ZOOM2X_EN
        e11 = 8'h00;
`else
        e11 = 8'h05;
`endif
        n_cmp++;
        if (obs_rgb[HT + 2] !== e11) begin
            n_bad++; $display("FAIL img4x3_rgb11: got %h expected %h", obs_rgb[HT + 2], e11);
        end
        n_cmp++;
        if (obs_rgb[2 * 4 + 1] !== 8'h00 || obs_rgb[6 * HT + 1] !== 8'h00) begin
            n_bad++; $display("FAIL img4x3_outside: got %h/%h expected 00/00", obs_rgb[9], obs_rgb[6 * HT + 1]);
        end
    endtask

    task automatic test_dim_change();
        int n11;
`ifdef ZOOM2X_EN
        n11 = 4 * HT + 7;
`else
        n11 = 2 * HT + 3;
`endif
        run_frame("dimchg", 10, 16'h0202);
        n_cmp++;
        if (obs_addr[n11] !== AW'(11)) begin
            n_bad++; $display("FAIL dimchg_keep: got %0d expected 11", obs_addr[n11]);
        end
    endtask

    task automatic test_2x2();
        run_frame("img2x2", FT / 2, 16'h0000);
`ifdef ZOOM2X_EN
        n_cmp++;
        if ({obs_addr[0], obs_addr[1], obs_addr[HT], obs_addr[HT + 1]} !== '0) begin
            n_bad++; $display("FAIL zoom_blk0: got %0d %0d %0d %0d expected 0", obs_addr[0], obs_addr[1],
                              obs_addr[HT], obs_addr[HT + 1]);
        end
        n_cmp++;
        if (obs_addr[2] !== AW'(1) || obs_addr[HT + 3] !== AW'(1)) begin
            n_bad++; $display("FAIL zoom_blk1: got %0d %0d expected 1", obs_addr[2], obs_addr[HT + 3]);
        end
        n_cmp++;
        if (obs_addr[2 * HT] !== AW'(2)) begin
            n_bad++; $display("FAIL zoom_line2: got %0d expected 2", obs_addr[2 * HT]);
        end
        n_cmp++;
        if (obs_rgb[3] !== 8'h01) begin
            n_bad++; $display("FAIL zoom_rgb20: got %h expected 01", obs_rgb[3]);
        end
`else
        n_cmp++;
        if (obs_addr[1] !== AW'(1) || obs_addr[HT] !== AW'(2)) begin
            n_bad++; $display("FAIL img2x2_addr: got %0d %0d expected 1 2", obs_addr[1], obs_addr[HT]);
        end
        n_cmp++;
        if (obs_rgb[HT + 2] !== 8'h03) begin
            n_bad++; $display("FAIL img2x2_rgb11: got %h expected 03", obs_rgb[HT + 2]);
        end
`endif
    endtask

    task automatic test_zero_size();
        int nz = 0;
        run_frame("zero", 10, {8'($urandom_range(1, 20)), 8'($urandom_range(1, 15))});
        for (int i = 0; i < FT; i++)
            if (obs_addr[i] !== '0 || obs_rgb[i] !== 8'h00) nz++;
        n_cmp++;
        if (nz != 0) begin
            n_bad++; $display("FAIL zero_frame: got %0d nonzero addr/rgb samples expected 0", nz);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++)
            run_frame("random", $urandom_range(1, FT - 2),
                      {8'($urandom_range(0, 20)), 8'($urandom_range(0, 15))});
    endtask

    initial begin
        reset = 1'b0;
        mem.dimensiones = 16'h0403;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_timing();
        test_image_4x3();
        test_dim_change();
        test_2x2();
        test_zero_size();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
